// File: rtl/phase_comp_pkg.sv
// rtl/phase_comp_pkg.sv - shared state encoding, step direction and coarse reset code
// Used by phase_comp_high_coarse_vote_filter (optional feature macro: PHASE_LOCK_DET_EN).
package phase_comp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Must match the reset code of the coarse phase register fed by sum_out.
   localparam logic [1:0] COARSE_RST = 2'b01;

endpackage

// File: rtl/phase_comp_high_coarse_vote_filter_if.sv
// rtl/phase_comp_high_coarse_vote_filter_if.sv - vote inputs and coarse-step outputs of the vote filter
// The slave side is the filter; the master side is the phase detector / coarse register pair.
interface phase_comp_high_coarse_vote_filter_if;
   logic       enable;
   logic       early;
   logic       late;
   logic [1:0] coarse_cur;
   logic [1:0] sum_out;
   logic       update_en;
   logic       step_dir;
   logic       lock;

   modport master (
      output enable, early, late, coarse_cur,
      input  sum_out, update_en, step_dir, lock
   );

   modport slave (
      input  enable, early, late, coarse_cur,
      output sum_out, update_en, step_dir, lock
   );
endinterface

// File: rtl/phase_comp_vote_sat_cnt.sv
// rtl/phase_comp_vote_sat_cnt.sv - signed saturating early/late vote accumulator with threshold compare
// Accumulator clears whenever run_i is low or a threshold is hit.
module phase_comp_vote_sat_cnt #(
   parameter int CNT_W  = 5,
   parameter int THRESH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   input  logic early_i,
   input  logic late_i,
   output logic hit_up_o,
   output logic hit_dn_o
);

   localparam logic signed [CNT_W-1:0] ACC_MAX = CNT_W'((2 ** (CNT_W - 1)) - 1);
   localparam logic signed [CNT_W-1:0] ACC_MIN = -ACC_MAX;
   localparam logic signed [CNT_W-1:0] THR_P   = CNT_W'(THRESH);
   localparam logic signed [CNT_W-1:0] THR_N   = -THR_P;
   localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);

   logic signed [CNT_W-1:0] acc_q;
   logic signed [CNT_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (early_i && !late_i && (acc_q != ACC_MAX)) begin
         acc_d = acc_q + ONE;
      end else if (late_i && !early_i && (acc_q != ACC_MIN)) begin
         acc_d = acc_q - ONE;
      end
   end

   assign hit_up_o = (acc_d >= THR_P);
   assign hit_dn_o = (acc_d <= THR_N);

   always_ff @(posedge clk) begin
      if (reset || !run_i || hit_up_o || hit_dn_o) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/phase_comp_high_coarse_vote_filter.sv
// rtl/phase_comp_high_coarse_vote_filter.sv - early/late vote filter stepping the 2-bit coarse phase code
// Optional lock detector built when PHASE_LOCK_DET_EN is defined.
module phase_comp_high_coarse_vote_filter
   import phase_comp_pkg::*;
#(
   parameter int CNT_W    = 5,
   parameter int THRESH   = 8,
   parameter int SETTLE   = 4,
   parameter int LOCK_CYC = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   phase_comp_high_coarse_vote_filter_if.slave bus
);

   state_e     state_q;
   logic [7:0] settle_q;
   logic [1:0] sum_q;
   logic       upd_q;
   logic       dir_q;
   logic       lock_q;
   logic       hit_up;
   logic       hit_dn;
   logic       acc_run;

   assign acc_run = bus.enable && (state_q == ST_ACCUM);

   phase_comp_vote_sat_cnt #(
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
   ) u_vote_cnt (
      .clk      (clk),
      .reset    (reset),
      .run_i    (acc_run),
      .early_i  (bus.early),
      .late_i   (bus.late),
      .hit_up_o (hit_up),
      .hit_dn_o (hit_dn)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         sum_q    <= COARSE_RST;
         upd_q    <= 1'b0;
         dir_q    <= DIR_DN;
      end else if (!bus.enable) begin
         // sum_out and step_dir keep the last step so the coarse register stays consistent.
         state_q <= ST_IDLE;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            ST_IDLE: state_q <= ST_ACCUM;
            ST_ACCUM: begin
               if (hit_up) begin
                  state_q <= ST_UPDATE;
                  sum_q   <= bus.coarse_cur + 2'd1;
                  dir_q   <= DIR_UP;
                  upd_q   <= 1'b1;
               end else if (hit_dn) begin
                  state_q <= ST_UPDATE;
                  sum_q   <= bus.coarse_cur - 2'd1;
                  dir_q   <= DIR_DN;
                  upd_q   <= 1'b1;
               end
            end
            ST_UPDATE: begin
               settle_q <= 8'(SETTLE);
               state_q  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               settle_q <= settle_q - 8'd1;
               if (settle_q == 8'd1) begin
                  state_q <= ST_ACCUM;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef PHASE_LOCK_DET_EN
   logic [7:0] quiet_q;

   always_ff @(posedge clk) begin
      if (reset || !bus.enable) begin
         quiet_q <= '0;
         lock_q  <= 1'b0;
      end else if (state_q == ST_ACCUM) begin
         if (hit_up || hit_dn) begin
            quiet_q <= '0;
            lock_q  <= 1'b0;
         end else begin
            if (quiet_q != 8'hFF) begin
               quiet_q <= quiet_q + 8'd1;
            end
            if (int'(quiet_q) >= LOCK_CYC - 1) begin
               lock_q <= 1'b1;
            end
         end
      end else if (state_q == ST_UPDATE) begin
         quiet_q <= '0;
      end
   end
`else
   logic unused_lock_cyc;
   assign unused_lock_cyc = (LOCK_CYC != 0);
   assign lock_q          = 1'b0;
`endif

   assign bus.sum_out   = sum_q;
   assign bus.update_en = upd_q;
   assign bus.step_dir  = dir_q;
   assign bus.lock      = lock_q;

endmodule
